// File: rtl/uart_boot_loader.sv
// uart_boot_loader
// Serial program loader for the instruction memory. A framed image arrives
// on a UART line: sync byte 8'hA5, a 16-bit little-endian word count N, then
// N little-endian 32-bit words. Each completed word is written to program
// memory with a single-cycle strobe. The core is held in reset until the
// image is complete.
//
// Optional build macro: BOOT_CHECKSUM_EN. When defined, an 8-bit XOR of all
// data bytes must follow the last word (a zero-length image expects 8'h00).
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   uart_rx    in   serial input, idle high (8N1, LSB first)
//   prog_we    out  program memory write strobe, one-cycle pulse
//   prog_addr  out  byte address of the write (BASE_ADDR + 4*word_index)
//   prog_wdata out  write data
//   core_hold  out  1 = keep core in reset
//   boot_done  out  image loaded, sticky until reset
//   boot_error out  protocol/framing/length error, sticky until reset
module uart_boot_loader #(
   parameter int          CLK_FREQ   = 50000000,
   parameter int          BAUD       = 115200,
   parameter logic [31:0] BASE_ADDR  = 32'h0040_0000,
   parameter int          MAX_WORDS  = 1024,
   parameter int          ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  uart_rx,
   output logic                  prog_we,
   output logic [ADDR_WIDTH-1:0] prog_addr,
   output logic [31:0]           prog_wdata,
   output logic                  core_hold,
   output logic                  boot_done,
   output logic                  boot_error
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int HALF_M1      = (CLKS_PER_BIT / 2 > 0) ? (CLKS_PER_BIT / 2 - 1) : 0;
   localparam int FULL_M1      = (CLKS_PER_BIT > 0) ? (CLKS_PER_BIT - 1) : 0;
   localparam int CW           = $clog2(CLKS_PER_BIT + 1);

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   localparam logic [2:0] WAIT_SYNC = 3'd0;
   localparam logic [2:0] LEN_LO    = 3'd1;
   localparam logic [2:0] LEN_HI    = 3'd2;
   localparam logic [2:0] DATA      = 3'd3;
`ifdef BOOT_CHECKSUM_EN
   localparam logic [2:0] CHECK     = 3'd4;
`endif
   localparam logic [2:0] DONE      = 3'd5;
   localparam logic [2:0] ERR       = 3'd6;

   logic                  rx_meta_r, rx_sync_r, rx_prev_r;
   logic [1:0]            rx_state_r;
   logic [CW-1:0]         clk_cnt_r;
   logic [2:0]            bit_idx_r;
   logic [7:0]            shift_r;
   logic                  byte_valid_r, frame_err_r;

   logic [2:0]            frm_state_r;
   logic [15:0]           len_r, word_idx_r;
   logic [1:0]            byte_cnt_r;
   logic [31:0]           word_r;
   logic                  prog_we_r;
   logic [ADDR_WIDTH-1:0] prog_addr_r;
   logic [31:0]           prog_wdata_r;
   logic                  core_hold_r, boot_done_r, boot_error_r;
   logic [15:0]           len_full_s;
   logic [31:0]           word_full_s;

`ifdef BOOT_CHECKSUM_EN
   logic [7:0]            csum_r;

   // Running XOR checksum over the data bytes.
   function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] data);
      csum_update = acc ^ data;
   endfunction
`endif

   assign len_full_s  = {shift_r, len_r[7:0]};
   // Bytes enter at the top so the first byte of a word ends up in [7:0].
   assign word_full_s = {shift_r, word_r[31:8]};

   // Two-flop synchronizer plus a delayed copy for falling-edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta_r <= 1'b1;
         rx_sync_r <= 1'b1;
         rx_prev_r <= 1'b1;
      end else begin
         rx_meta_r <= uart_rx;
         rx_sync_r <= rx_meta_r;
         rx_prev_r <= rx_sync_r;
      end
   end

   // Byte receiver: mid-bit sampling, emits byte_valid or frame_err pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_state_r   <= RX_IDLE;
         clk_cnt_r    <= {CW{1'b0}};
         bit_idx_r    <= 3'd0;
         shift_r      <= 8'd0;
         byte_valid_r <= 1'b0;
         frame_err_r  <= 1'b0;
      end else begin
         byte_valid_r <= 1'b0;
         frame_err_r  <= 1'b0;
         case (rx_state_r)
            RX_IDLE: begin
               if (rx_prev_r && !rx_sync_r) begin
                  rx_state_r <= RX_START;
                  clk_cnt_r  <= CW'(HALF_M1);
               end
            end
            RX_START: begin
               if (clk_cnt_r != {CW{1'b0}}) begin
                  clk_cnt_r <= clk_cnt_r - CW'(1);
               end else if (!rx_sync_r) begin
                  rx_state_r <= RX_DATA;
                  clk_cnt_r  <= CW'(FULL_M1);
                  bit_idx_r  <= 3'd0;
               end else begin
                  // Line went back high: a glitch, not a start bit.
                  rx_state_r <= RX_IDLE;
               end
            end
            RX_DATA: begin
               if (clk_cnt_r != {CW{1'b0}}) begin
                  clk_cnt_r <= clk_cnt_r - CW'(1);
               end else begin
                  shift_r   <= {rx_sync_r, shift_r[7:1]};
                  clk_cnt_r <= CW'(FULL_M1);
                  if (bit_idx_r == 3'd7) begin
                     rx_state_r <= RX_STOP;
                  end else begin
                     bit_idx_r <= bit_idx_r + 3'd1;
                  end
               end
            end
            RX_STOP: begin
               if (clk_cnt_r != {CW{1'b0}}) begin
                  clk_cnt_r <= clk_cnt_r - CW'(1);
               end else begin
                  if (rx_sync_r) begin
                     byte_valid_r <= 1'b1;
                  end else begin
                     frame_err_r <= 1'b1;
                  end
                  rx_state_r <= RX_IDLE;
               end
            end
            default: rx_state_r <= RX_IDLE;
         endcase
      end
   end

   // Frame FSM: parses sync/length/data and drives the program write port.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frm_state_r  <= WAIT_SYNC;
         len_r        <= 16'd0;
         word_idx_r   <= 16'd0;
         byte_cnt_r   <= 2'd0;
         word_r       <= 32'd0;
         prog_we_r    <= 1'b0;
         prog_addr_r  <= {ADDR_WIDTH{1'b0}};
         prog_wdata_r <= 32'd0;
`ifdef BOOT_CHECKSUM_EN
         csum_r       <= 8'd0;
`endif
      end else begin
         prog_we_r <= 1'b0;
         case (frm_state_r)
            WAIT_SYNC: begin
               if (byte_valid_r && (shift_r == 8'hA5)) begin
                  frm_state_r <= LEN_LO;
`ifdef BOOT_CHECKSUM_EN
                  csum_r      <= 8'd0;
`endif
               end
            end
            LEN_LO: begin
               if (frame_err_r) begin
                  frm_state_r <= ERR;
               end else if (byte_valid_r) begin
                  len_r[7:0]  <= shift_r;
                  frm_state_r <= LEN_HI;
               end
            end
            LEN_HI: begin
               if (frame_err_r) begin
                  frm_state_r <= ERR;
               end else if (byte_valid_r) begin
                  len_r      <= len_full_s;
                  word_idx_r <= 16'd0;
                  byte_cnt_r <= 2'd0;
                  if (len_full_s == 16'd0) begin
`ifdef BOOT_CHECKSUM_EN
                     frm_state_r <= CHECK;
`else
                     frm_state_r <= DONE;
`endif
                  end else if ({16'd0, len_full_s} > 32'(MAX_WORDS)) begin
                     frm_state_r <= ERR;
                  end else begin
                     frm_state_r <= DATA;
                  end
               end
            end
            DATA: begin
               if (frame_err_r) begin
                  frm_state_r <= ERR;
               end else if (byte_valid_r) begin
                  word_r     <= word_full_s;
                  byte_cnt_r <= byte_cnt_r + 2'd1;
`ifdef BOOT_CHECKSUM_EN
                  csum_r     <= csum_update(csum_r, shift_r);
`endif
                  if (byte_cnt_r == 2'd3) begin
                     prog_we_r    <= 1'b1;
                     prog_addr_r  <= ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'({word_idx_r, 2'b00});
                     prog_wdata_r <= word_full_s;
                     word_idx_r   <= word_idx_r + 16'd1;
                     if (word_idx_r == (len_r - 16'd1)) begin
`ifdef BOOT_CHECKSUM_EN
                        frm_state_r <= CHECK;
`else
                        frm_state_r <= DONE;
`endif
                     end
                  end
               end
            end
`ifdef BOOT_CHECKSUM_EN
            CHECK: begin
               if (frame_err_r) begin
                  frm_state_r <= ERR;
               end else if (byte_valid_r) begin
                  frm_state_r <= (shift_r == csum_r) ? DONE : ERR;
               end
            end
`endif
            DONE:    frm_state_r <= DONE;
            ERR:     frm_state_r <= ERR;
            default: frm_state_r <= ERR;
         endcase
      end
   end

   // Status outputs registered from the frame state; DONE and ERR are terminal.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         core_hold_r  <= 1'b1;
         boot_done_r  <= 1'b0;
         boot_error_r <= 1'b0;
      end else begin
         core_hold_r  <= (frm_state_r != DONE);
         boot_done_r  <= (frm_state_r == DONE);
         boot_error_r <= (frm_state_r == ERR);
      end
   end

   assign prog_we    = prog_we_r;
   assign prog_addr  = prog_addr_r;
   assign prog_wdata = prog_wdata_r;
   assign core_hold  = core_hold_r;
   assign boot_done  = boot_done_r;
   assign boot_error = boot_error_r;

endmodule
